// File: rtl/snake_head_ctrl_pkg.sv
// Shared encodings for the snake head controller: direction codes, game states and
// the reverse-direction helper used by the heading commit logic.
package snake_head_ctrl_pkg;

    localparam logic [1:0] TOP_DIR   = 2'd0;
    localparam logic [1:0] DOWN_DIR  = 2'd1;
    localparam logic [1:0] LEFT_DIR  = 2'd2;
    localparam logic [1:0] RIGHT_DIR = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDead  = 2'd3
    } game_state_e;

    function automatic logic [1:0] reverse_dir(input logic [1:0] dir);
        logic [1:0] rev;
        case (dir)
            TOP_DIR:  rev = DOWN_DIR;
            DOWN_DIR: rev = TOP_DIR;
            LEFT_DIR: rev = RIGHT_DIR;
            default:  rev = LEFT_DIR;
        endcase
        return rev;
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-step prescaler: counts 0..MOVE_DIV-1 while en is high and flags the terminal
// count combinationally so the consumer can act on the following edge.
module snake_tick_gen #(
    parameter int unsigned MOVE_DIV = 25_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(MOVE_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MOVE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake game step controller: move prescaler, heading register, head position and the
// IDLE/RUN/PAUSE/DEAD FSM. Define WRAP_WALLS_EN to wrap at playfield edges instead of dying.
module snake_head_ctrl
    import snake_head_ctrl_pkg::*;
#(
    parameter int unsigned GRID_W   = 40,
    parameter int unsigned GRID_H   = 30,
    parameter int unsigned X_W      = 6,
    parameter int unsigned Y_W      = 5,
    parameter int unsigned MOVE_DIV = 25_000_000,
    parameter int unsigned START_X  = 20,
    parameter int unsigned START_Y  = 15
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           start,
    input  logic           pause,
    input  logic [1:0]     direction,
    input  logic           collide,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [1:0]     heading,
    output logic           move_tick,
    output logic           game_over
);

    localparam logic [X_W-1:0] INIT_X = START_X[X_W-1:0];
    localparam logic [Y_W-1:0] INIT_Y = START_Y[Y_W-1:0];
    localparam logic [X_W:0]   X_LIM  = GRID_W[X_W:0];
    localparam logic [Y_W:0]   Y_LIM  = GRID_H[Y_W:0];

    game_state_e    state_q;
    logic [X_W-1:0] head_x_q;
    logic [Y_W-1:0] head_y_q;
    logic [1:0]     heading_q;
    logic           move_tick_q;
    logic           game_over_q;

    logic           tick_en;
    logic           tick_clr;
    logic           step;
    logic [1:0]     new_heading;
    logic [X_W:0]   nx;
    logic [Y_W:0]   ny;
    logic           wall_hit;

    // Collide and pause take priority, so the counter must not advance in their cycle
    // either; that keeps a pending step pending across a pause.
    assign tick_en  = (state_q == StRun) && !collide && !pause;
    assign tick_clr = (state_q == StIdle);

    snake_tick_gen #(
        .MOVE_DIV(MOVE_DIV)
    ) u_tick_gen (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .en       (tick_en),
        .clr      (tick_clr),
        .tick     (step)
    );

    assign new_heading = (direction == reverse_dir(heading_q)) ? heading_q : direction;

    // One extra bit makes both x+1 == GRID_W and 0-1 (all ones) compare as out of range.
    always_comb begin
        nx       = {1'b0, head_x_q};
        ny       = {1'b0, head_y_q};
        wall_hit = 1'b0;
        case (new_heading)
            TOP_DIR:  ny = ny - 1'b1;
            DOWN_DIR: ny = ny + 1'b1;
            LEFT_DIR: nx = nx - 1'b1;
            default:  nx = nx + 1'b1;
        endcase
`ifdef WRAP_WALLS_EN
        if (nx >= X_LIM) begin
            nx = (new_heading == RIGHT_DIR) ? '0 : X_LIM - 1'b1;
        end
        if (ny >= Y_LIM) begin
            ny = (new_heading == DOWN_DIR) ? '0 : Y_LIM - 1'b1;
        end
`else
        wall_hit = (nx >= X_LIM) || (ny >= Y_LIM);
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            head_x_q    <= INIT_X;
            head_y_q    <= INIT_Y;
            heading_q   <= TOP_DIR;
            move_tick_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            move_tick_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (collide) begin
                        state_q     <= StDead;
                        game_over_q <= 1'b1;
                    end else if (pause) begin
                        state_q <= StPause;
                    end else if (step) begin
                        heading_q <= new_heading;
                        if (wall_hit) begin
                            state_q     <= StDead;
                            game_over_q <= 1'b1;
                        end else begin
                            head_x_q    <= nx[X_W-1:0];
                            head_y_q    <= ny[Y_W-1:0];
                            move_tick_q <= 1'b1;
                        end
                    end
                end
                StPause: begin
                    if (!pause) begin
                        state_q <= StRun;
                    end
                end
                StDead: begin
                    if (start) begin
                        state_q     <= StIdle;
                        head_x_q    <= INIT_X;
                        head_y_q    <= INIT_Y;
                        heading_q   <= TOP_DIR;
                        game_over_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign head_x    = head_x_q;
    assign head_y    = head_y_q;
    assign heading   = heading_q;
    assign move_tick = move_tick_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed bench for snake_head_ctrl with MOVE_DIV=4, 8x6 grid, start (4,3).
// Expectations follow WRAP_WALLS_EN when it is defined for the build.
module tb_snake_head_ctrl;
    import snake_head_ctrl_pkg::*;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       start;
    logic       pause;
    logic [1:0] direction;
    logic       collide;
    logic [2:0] head_x;
    logic [2:0] head_y;
    logic [1:0] heading;
    logic       move_tick;
    logic       game_over;

    int checks;
    int failures;

    snake_head_ctrl #(
        .GRID_W  (8),
        .GRID_H  (6),
        .X_W     (3),
        .Y_W     (3),
        .MOVE_DIV(4),
        .START_X (4),
        .START_Y (3)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .start    (start),
        .pause    (pause),
        .direction(direction),
        .collide  (collide),
        .head_x   (head_x),
        .head_y   (head_y),
        .heading  (heading),
        .move_tick(move_tick),
        .game_over(game_over)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_value(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic check_state(input string tag, input int ex_x, input int ex_y,
                               input int ex_hd, input int ex_tick, input int ex_go);
        check_value({tag, ".x"}, int'(head_x), ex_x);
        check_value({tag, ".y"}, int'(head_y), ex_y);
        check_value({tag, ".heading"}, int'(heading), ex_hd);
        check_value({tag, ".tick"}, int'(move_tick), ex_tick);
        check_value({tag, ".game_over"}, int'(game_over), ex_go);
    endtask

    // Called one cycle after a step (or after the start edge): the next step is 4 edges on.
    task automatic step_and_check(input string tag, input int ex_x, input int ex_y,
                                  input int ex_hd, input int ex_tick, input int ex_go);
        repeat (3) @(negedge sys_clk);
        check_value({tag, ".pre_tick"}, int'(move_tick), 0);
        @(negedge sys_clk);
        check_state(tag, ex_x, ex_y, ex_hd, ex_tick, ex_go);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        sys_rst_n = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        direction = RIGHT_DIR;
        collide   = 1'b0;

        #12;
        check_state("reset", 4, 3, int'(TOP_DIR), 0, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_state("idle_hold", 4, 3, int'(TOP_DIR), 0, 0);

        // Basic stepping, reverse rejection and a turn.
        pulse_start();
        step_and_check("right1", 5, 3, int'(RIGHT_DIR), 1, 0);
        step_and_check("right2", 6, 3, int'(RIGHT_DIR), 1, 0);
        direction = LEFT_DIR;
        step_and_check("reverse", 7, 3, int'(RIGHT_DIR), 1, 0);
        direction = TOP_DIR;
        step_and_check("turn_top", 7, 2, int'(TOP_DIR), 1, 0);

        // Pause raised on the terminal-count cycle.
        repeat (3) @(negedge sys_clk);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check_value("paused.tick", int'(move_tick), 0);
        end
        check_state("paused", 7, 2, int'(TOP_DIR), 0, 0);
        pause = 1'b0;
        @(negedge sys_clk);
        check_value("resume.pre_tick", int'(move_tick), 0);
        @(negedge sys_clk);
        check_state("resume", 7, 1, int'(TOP_DIR), 1, 0);

        // Collide on a step cycle beats the step.
        repeat (3) @(negedge sys_clk);
        collide = 1'b1;
        @(negedge sys_clk);
        collide = 1'b0;
        check_state("collide", 7, 1, int'(TOP_DIR), 0, 1);
        repeat (3) @(negedge sys_clk);
        check_state("dead_hold", 7, 1, int'(TOP_DIR), 0, 1);
        pulse_start();
        check_state("dead_to_idle", 4, 3, int'(TOP_DIR), 0, 0);
        pulse_start();

        // Right wall.
        direction = RIGHT_DIR;
        step_and_check("wall_x5", 5, 3, int'(RIGHT_DIR), 1, 0);
        step_and_check("wall_x6", 6, 3, int'(RIGHT_DIR), 1, 0);
        step_and_check("wall_x7", 7, 3, int'(RIGHT_DIR), 1, 0);
`ifdef WRAP_WALLS_EN
        step_and_check("wall_x_wrap", 0, 3, int'(RIGHT_DIR), 1, 0);
        direction = TOP_DIR;
        step_and_check("wall_y2", 0, 2, int'(TOP_DIR), 1, 0);
        step_and_check("wall_y1", 0, 1, int'(TOP_DIR), 1, 0);
        step_and_check("wall_y0", 0, 0, int'(TOP_DIR), 1, 0);
        step_and_check("wall_y_wrap", 0, 5, int'(TOP_DIR), 1, 0);
        direction = RIGHT_DIR;
        step_and_check("pre_reset", 1, 5, int'(RIGHT_DIR), 1, 0);
`else
        step_and_check("wall_x_dead", 7, 3, int'(RIGHT_DIR), 0, 1);
        pulse_start();
        pulse_start();
        direction = TOP_DIR;
        step_and_check("wall_y2", 4, 2, int'(TOP_DIR), 1, 0);
        step_and_check("wall_y1", 4, 1, int'(TOP_DIR), 1, 0);
        step_and_check("wall_y0", 4, 0, int'(TOP_DIR), 1, 0);
        step_and_check("wall_y_dead", 4, 0, int'(TOP_DIR), 0, 1);
        pulse_start();
        pulse_start();
        direction = RIGHT_DIR;
        step_and_check("pre_reset", 5, 3, int'(RIGHT_DIR), 1, 0);
`endif

        // Asynchronous reset in the middle of a run.
        @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_state("async_reset", 4, 3, int'(TOP_DIR), 0, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_state("after_reset", 4, 3, int'(TOP_DIR), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
